// File: rtl/delay_timer_bank_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : delay_timer_bank_if
// Brief    : Control/status bundle for the delay timer bank. The master side
//            issues start/stop requests with mode and period per channel; the
//            slave side returns busy, done pulses and the live down-count.
// Revision : 1.0  initial release
// ============================================================================
interface delay_timer_bank_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16
);
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       stop;
    logic [NUM_CH-1:0]       periodic;
    logic [NUM_CH*WIDTH-1:0] period;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;
    logic [NUM_CH*WIDTH-1:0] remaining;

    modport master (
        output start,
        output stop,
        output periodic,
        output period,
        input  busy,
        input  done,
        input  remaining
    );

    modport slave (
        input  start,
        input  stop,
        input  periodic,
        input  period,
        output busy,
        output done,
        output remaining
    );
endinterface
`default_nettype wire

// File: rtl/delay_timer_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : delay_timer_bank
// Brief    : Bank of NUM_CH independent programmable delay timers sharing one
//            free-running prescaler. Each channel counts a programmed number
//            of prescaled ticks and emits a one-cycle done pulse, once
//            (one-shot) or repeatedly (periodic).
// Revision : 1.0  initial release
// ============================================================================
module delay_timer_bank #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    delay_timer_bank_if.slave  bus
);

    // Prescaler counter width; a single bit is kept even when PRESCALE = 1
    // so the tick compare stays well-formed.
    localparam int                  c_PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRE_W-1:0]  c_PRE_MAX = c_PRE_W'(PRESCALE - 1);

    localparam logic [0:0]          c_IDLE    = 1'b0;
    localparam logic [0:0]          c_RUN     = 1'b1;

    localparam logic [WIDTH-1:0]    c_CNT_ONE = WIDTH'(1);

    logic [c_PRE_W-1:0] r_pre;
    logic               w_tick;

    // Tick marks the last cycle of each prescaler period; with PRESCALE = 1
    // the counter sits at zero and every cycle is a tick.
    assign w_tick = (r_pre == c_PRE_MAX);

    // Free-running prescaler, never gated by channel activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [0:0]       r_state;
            logic [WIDTH-1:0] r_count;
            logic [WIDTH-1:0] r_reload;
            logic             r_mode;
            logic             r_done;

            logic [WIDTH-1:0] w_period;
            logic             w_start;
            logic             w_stop;
            logic             w_per_zero;

            assign w_period   = bus.period[i*WIDTH +: WIDTH];
            assign w_start    = bus.start[i];
            assign w_stop     = bus.stop[i];
            assign w_per_zero = (w_period == '0);

            // Channel state machine: stop outranks restart, restart outranks
            // expiry, and the count never drops below one while running.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state  <= c_IDLE;
                    r_count  <= '0;
                    r_reload <= '0;
                    r_mode   <= 1'b0;
                    r_done   <= 1'b0;
                end else begin
                    r_done <= 1'b0;
                    case (r_state)
                        c_IDLE: begin
                            // A zero period would never expire, so it is
                            // simply not accepted.
                            if (w_start && !w_stop && !w_per_zero) begin
                                r_state  <= c_RUN;
                                r_count  <= w_period;
                                r_reload <= w_period;
                                r_mode   <= bus.periodic[i];
                            end
                        end
                        c_RUN: begin
                            if (w_stop || (w_start && w_per_zero)) begin
                                // Abort; a restart with zero period acts the same.
                                r_state <= c_IDLE;
                                r_count <= '0;
                            end else if (w_start) begin
                                // Restart swallows any coincident expiry.
                                r_count  <= w_period;
                                r_reload <= w_period;
                                r_mode   <= bus.periodic[i];
                            end else if (w_tick) begin
                                if (r_count == c_CNT_ONE) begin
                                    r_done <= 1'b1;
                                    if (r_mode) begin
                                        r_count <= r_reload;
                                    end else begin
                                        r_count <= '0;
                                        r_state <= c_IDLE;
                                    end
                                end else begin
                                    r_count <= r_count - c_CNT_ONE;
                                end
                            end
                        end
                        default: begin
                            r_state <= c_IDLE;
                            r_count <= '0;
                        end
                    endcase
                end
            end

            assign bus.busy[i]                    = (r_state == c_RUN);
            assign bus.done[i]                    = r_done;
            assign bus.remaining[i*WIDTH +: WIDTH] = r_count;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_delay_timer_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_delay_timer_bank
// Brief    : Self-checking bench for delay_timer_bank. A vector table drives
//            a PRESCALE=1 bank cycle by cycle; hand-written sequences cover
//            the prescaled periodic mode, the 4-bit no-wrap boundary and an
//            asynchronous reset in the middle of a run.
// Revision : 1.0  initial release
// ============================================================================
module tb_delay_timer_bank;

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;
    logic rst_n_c;

    always #5 clk = ~clk;

    delay_timer_bank_if #(.NUM_CH(4), .WIDTH(16)) bus_a ();
    delay_timer_bank_if #(.NUM_CH(4), .WIDTH(16)) bus_b ();
    delay_timer_bank_if #(.NUM_CH(4), .WIDTH(4))  bus_c ();

    delay_timer_bank #(.NUM_CH(4), .WIDTH(16), .PRESCALE(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (bus_a)
    );

    delay_timer_bank #(.NUM_CH(4), .WIDTH(16), .PRESCALE(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (bus_b)
    );

    delay_timer_bank #(.NUM_CH(4), .WIDTH(4), .PRESCALE(1)) u_dut_c (
        .clk   (clk),
        .rst_n (rst_n_c),
        .bus   (bus_c)
    );

    typedef struct packed {
        logic [3:0]  start;
        logic [3:0]  stop;
        logic [3:0]  periodic;
        logic [63:0] period;
        logic [3:0]  busy;
        logic [3:0]  done;
        logic [63:0] rem;
    } vec_t;

    vec_t tbl [$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Period and remaining arguments are listed channel 3 first, channel 0 last.
    task automatic add(input logic [3:0] st, input logic [3:0] sp, input logic [3:0] pm,
                       input logic [15:0] p3, input logic [15:0] p2,
                       input logic [15:0] p1, input logic [15:0] p0,
                       input logic [3:0] bz, input logic [3:0] dn,
                       input logic [15:0] r3, input logic [15:0] r2,
                       input logic [15:0] r1, input logic [15:0] r0);
        vec_t v;
        v.start    = st;
        v.stop     = sp;
        v.periodic = pm;
        v.period   = {p3, p2, p1, p0};
        v.busy     = bz;
        v.done     = dn;
        v.rem      = {r3, r2, r1, r0};
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.start    = '0;
        bus_a.stop     = '0;
        bus_a.periodic = '0;
        bus_a.period   = '0;
    endtask

    initial begin
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        rst_n_c = 1'b0;
        idle_a();
        bus_b.start = '0; bus_b.stop = '0; bus_b.periodic = '0; bus_b.period = '0;
        bus_c.start = '0; bus_c.stop = '0; bus_c.periodic = '0; bus_c.period = '0;

        // ---------------- table: PRESCALE=1 bank ----------------
        // independence: P=2,3,4,5 on ch0..ch3, all one-shot
        add(4'b1111, 4'b0, 4'b0, 5, 4, 3, 2, 4'b1111, 4'b0000, 5, 4, 3, 2);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b1111, 4'b0000, 4, 3, 2, 1);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b1110, 4'b0001, 3, 2, 1, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b1100, 4'b0010, 2, 1, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b1000, 4'b0100, 1, 0, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b1000, 0, 0, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        // one-shot ch0 P=5
        add(4'b0001, 4'b0, 4'b0, 0, 0, 0, 5, 4'b0001, 4'b0000, 0, 0, 0, 5);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 4);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 3);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 2);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 1);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        // start with P=0 is ignored
        add(4'b0010, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        // P=1 on ch2
        add(4'b0100, 4'b0, 4'b0, 0, 1, 0, 0, 4'b0100, 4'b0000, 0, 1, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0100, 0, 0, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        // restart coinciding with expiry on ch2: P=4 then P=6
        add(4'b0100, 4'b0, 4'b0, 0, 4, 0, 0, 4'b0100, 4'b0000, 0, 4, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 3, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 2, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 1, 0, 0);
        add(4'b0100, 4'b0, 4'b0, 0, 6, 0, 0, 4'b0100, 4'b0000, 0, 6, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 5, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 4, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 3, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 2, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 1, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0100, 0, 0, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        // stop coinciding with expiry on ch2
        add(4'b0100, 4'b0, 4'b0, 0, 4, 0, 0, 4'b0100, 4'b0000, 0, 4, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 3, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 2, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 1, 0, 0);
        add(4'b0000, 4'b0100, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        // restart with P=0 while running acts as stop (ch3)
        add(4'b1000, 4'b0, 4'b0, 3, 0, 0, 0, 4'b1000, 4'b0000, 3, 0, 0, 0);
        add(4'b1000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        // periodic ch0 P=2, then stop
        add(4'b0001, 4'b0, 4'b0001, 0, 0, 0, 2, 4'b0001, 4'b0000, 0, 0, 0, 2);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 1);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0001, 4'b0001, 0, 0, 0, 2);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 1);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0001, 4'b0001, 0, 0, 0, 2);
        add(4'b0000, 4'b0001, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        // start together with stop from IDLE is ignored
        add(4'b0010, 4'b0010, 4'b0, 0, 0, 3, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(4'b0000, 4'b0, 4'b0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);

        // ---------------- reset state ----------------
        #12;
        chk("reset_a.busy", {60'd0, bus_a.busy}, 64'd0);
        chk("reset_a.done", {60'd0, bus_a.done}, 64'd0);
        chk("reset_a.remaining", bus_a.remaining, 64'd0);
        chk("reset_b.busy", {60'd0, bus_b.busy}, 64'd0);
        chk("reset_c.remaining", {48'd0, bus_c.remaining}, 64'd0);
        rst_n_a = 1'b1;
        rst_n_c = 1'b1;

        // ---------------- table apply ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            bus_a.start    = tbl[i].start;
            bus_a.stop     = tbl[i].stop;
            bus_a.periodic = tbl[i].periodic;
            bus_a.period   = tbl[i].period;
            step();
            chk($sformatf("tbl[%0d].busy", i), {60'd0, bus_a.busy}, {60'd0, tbl[i].busy});
            chk($sformatf("tbl[%0d].done", i), {60'd0, bus_a.done}, {60'd0, tbl[i].done});
            chk($sformatf("tbl[%0d].remaining", i), bus_a.remaining, tbl[i].rem);
        end
        idle_a();

        // ---------------- reset in the middle of a run ----------------
        bus_a.start  = 4'b0001;
        bus_a.period = 64'd10;
        step();
        idle_a();
        chk("rstmid.start_rem", bus_a.remaining, 64'd10);
        step(); step(); step();
        #2;
        rst_n_a = 1'b0;
        #1;
        chk("rstmid.async_busy", {60'd0, bus_a.busy}, 64'd0);
        chk("rstmid.async_done", {60'd0, bus_a.done}, 64'd0);
        chk("rstmid.async_rem", bus_a.remaining, 64'd0);
        step(); step();
        chk("rstmid.held_busy", {60'd0, bus_a.busy}, 64'd0);
        rst_n_a = 1'b1;
        for (int n = 0; n < 12; n++) begin
            step();
            chk($sformatf("rstmid.after[%0d].busy", n), {60'd0, bus_a.busy}, 64'd0);
            chk($sformatf("rstmid.after[%0d].done", n), {60'd0, bus_a.done}, 64'd0);
        end

        // ---------------- WIDTH=4, P=15: full range without wrap ----------------
        bus_c.start  = 4'b0001;
        bus_c.period = 16'h000F;
        step();
        bus_c.start  = '0;
        bus_c.period = '0;
        for (int n = 0; n <= 16; n++) begin
            logic [3:0]  eb;
            logic [3:0]  ed;
            logic [15:0] er;
            if (n > 0) step();
            eb = (n < 15) ? 4'b0001 : 4'b0000;
            ed = (n == 15) ? 4'b0001 : 4'b0000;
            er = (n < 15) ? 16'(15 - n) : 16'd0;
            chk($sformatf("w4[%0d].busy", n), {60'd0, bus_c.busy}, {60'd0, eb});
            chk($sformatf("w4[%0d].done", n), {60'd0, bus_c.done}, {60'd0, ed});
            chk($sformatf("w4[%0d].remaining", n), {48'd0, bus_c.remaining}, {48'd0, er});
        end

        // ---------------- PRESCALE=4, periodic ch1 P=3 ----------------
        // Released mid-cycle: edges 1..3 bring the prescaler to 3, so the
        // fourth edge is a tick edge and the start lands on it.
        rst_n_b = 1'b1;
        step(); step(); step();
        bus_b.start    = 4'b0010;
        bus_b.periodic = 4'b0010;
        bus_b.period   = {16'd0, 16'd0, 16'd3, 16'd0};
        for (int n = 0; n <= 48; n++) begin
            logic        d;
            logic [15:0] r;
            step();
            if (n == 0) begin
                bus_b.start    = '0;
                bus_b.periodic = '0;
                bus_b.period   = '0;
            end
            d = (n > 0) && (n % 12 == 0);
            r = 16'(3 - ((n / 4) % 3));
            chk($sformatf("per[%0d].busy", n), {60'd0, bus_b.busy}, 64'h2);
            chk($sformatf("per[%0d].done", n), {60'd0, bus_b.done}, {62'd0, d, 1'b0});
            chk($sformatf("per[%0d].remaining", n), bus_b.remaining, {32'd0, r, 16'd0});
        end
        bus_b.stop = 4'b0010;
        step();
        bus_b.stop = '0;
        chk("per.stop_busy", {60'd0, bus_b.busy}, 64'd0);
        chk("per.stop_rem", bus_b.remaining, 64'd0);
        for (int n = 0; n < 16; n++) begin
            step();
            chk($sformatf("per.after[%0d].done", n), {60'd0, bus_b.done}, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
